// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, defaults and select-width helper for bus_arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ    = 32;
  localparam int DEF_MAX_HOLD = 8;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker; search starts one past last_owner
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int SEL_W = sel_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_owner,
  output logic [N_REQ-1:0] winner,
  output logic [SEL_W-1:0] index,
  output logic             any
);

  int cand;

  // last_owner itself is visited last, so a requester that just released ranks lowest
  always_comb begin
    any   = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_owner) + i) % N_REQ;
      if (!any && req[cand]) begin
        any   = 1'b1;
        index = cand[SEL_W-1:0];
      end
    end
  end

  assign winner = any ? ({{(N_REQ-1){1'b0}}, 1'b1} << index) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with turnaround cycle
// Owner timeout/preemption is built only when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int SEL_W    = sel_width(N_REQ),
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             preempt
);

  arb_state_t       state, state_d;
  logic [N_REQ-1:0] grant_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] last_owner, last_d;
  logic             preempt_d;
  logic             expire;

  logic [N_REQ-1:0] pick_grant;
  logic [SEL_W-1:0] pick_sel;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
    .req       (req),
    .last_owner(last_owner),
    .winner    (pick_grant),
    .index     (pick_sel),
    .any       (pick_any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int            CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_cnt;

  // Counts owned cycles already completed; zero in the first owned cycle, saturates at the limit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state != ST_OWN) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign expire = (state == ST_OWN) && (hold_cnt == HOLD_LAST) && (|(req & ~grant));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign expire = 1'b0;
`endif

  // Arbitration runs from IDLE and on the edge that ends TURN, giving a single dead cycle
  always_comb begin
    state_d   = state;
    grant_d   = grant;
    sel_d     = sel;
    last_d    = last_owner;
    preempt_d = 1'b0;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (pick_any) begin
          state_d = ST_OWN;
          grant_d = pick_grant;
          sel_d   = pick_sel;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          sel_d   = '0;
        end
      end
      ST_OWN: begin
        if (!req[sel] || expire) begin
          state_d   = ST_TURN;
          grant_d   = '0;
          sel_d     = '0;
          last_d    = sel;
          preempt_d = req[sel];
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      sel        <= '0;
      last_owner <= SEL_W'(N_REQ - 1);
      preempt    <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      sel        <= sel_d;
      last_owner <= last_d;
      preempt    <= preempt_d;
    end
  end

  assign sel_valid = (state == ST_OWN);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (both BUS_ARB_TIMEOUT_EN builds)
module tb_bus_arbiter;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] req     = '0;
  logic [31:0] grant;
  logic [4:0]  sel;
  logic        sel_valid;
  logic        preempt;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.N_REQ(32), .MAX_HOLD(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .sel_valid(sel_valid),
    .preempt  (preempt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] eg, input int es, input logic ep);
    check({tag, ".grant"}, grant, eg);
    check({tag, ".sel"}, {27'b0, sel}, 32'(es));
    check({tag, ".valid"}, {31'b0, sel_valid}, {31'b0, (eg != 32'h0)});
    check({tag, ".preempt"}, {31'b0, preempt}, {31'b0, ep});
  endtask

  initial begin
    logic [31:0] one;

    // reset state
    tick();
    tick();
    chk_bus("rst", 32'h0, 0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_bus("idle0", 32'h0, 0, 1'b0);

    // first arbitration favours requester 0, then handover to 2 after one dead cycle
    req = 32'h0000_0005;
    tick();
    chk_bus("first", 32'h1, 0, 1'b0);
    tick();
    chk_bus("hold0", 32'h1, 0, 1'b0);
    req = 32'h0000_0004;
    tick();
    chk_bus("turn0", 32'h0, 0, 1'b0);
    tick();
    chk_bus("own2", 32'h4, 2, 1'b0);
    req = 32'h0;
    tick();
    chk_bus("rel2", 32'h0, 0, 1'b0);
    tick();
    chk_bus("idle1", 32'h0, 0, 1'b0);

    // full rotation with all requesters active
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    req = 32'hFFFF_FFFF;
    tick();
    for (int k = 0; k <= 32; k++) begin
      one = 32'h1 << (k % 32);
      chk_bus($sformatf("rot%0d", k), one, k % 32, 1'b0);
      req = ~one;
      tick();
      chk_bus($sformatf("rot%0d_turn", k), 32'h0, 0, 1'b0);
      req = (k == 32) ? 32'h0 : 32'hFFFF_FFFF;
      tick();
    end
    chk_bus("rot_idle", 32'h0, 0, 1'b0);

    // short pulse on 7 while 3 owns is lost
    req = 32'h0000_0008;
    tick();
    chk_bus("own3", 32'h8, 3, 1'b0);
    req = 32'h0000_0088;
    tick();
    chk_bus("own3_p7", 32'h8, 3, 1'b0);
    req = 32'h0000_0008;
    tick();
    chk_bus("own3_b", 32'h8, 3, 1'b0);
    req = 32'h0;
    tick();
    chk_bus("turn3", 32'h0, 0, 1'b0);
    tick();
    chk_bus("no7_a", 32'h0, 0, 1'b0);
    tick();
    chk_bus("no7_b", 32'h0, 0, 1'b0);

    // owner 5 with competitor 9
    req = 32'h0000_0220;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_bus($sformatf("hold5_%0d", i), 32'h20, 5, 1'b0);
      tick();
    end
`ifdef BUS_ARB_TIMEOUT_EN
    chk_bus("preempt5", 32'h0, 0, 1'b1);
    tick();
    chk_bus("own9", 32'h200, 9, 1'b0);
`else
    chk_bus("keep5_a", 32'h20, 5, 1'b0);
    tick();
    chk_bus("keep5_b", 32'h20, 5, 1'b0);
`endif
    req = 32'h0;
    tick();
    chk_bus("rel_a", 32'h0, 0, 1'b0);
    tick();
    chk_bus("rel_b", 32'h0, 0, 1'b0);

    // owner 5 alone is never preempted
    req = 32'h0000_0020;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk_bus($sformatf("solo5_%0d", i), 32'h20, 5, 1'b0);
      tick();
    end
    req = 32'h0;
    tick();
    tick();

    // release coinciding with timeout expiry is a normal release
    req = 32'h0000_0042;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk_bus($sformatf("own6_%0d", i), 32'h40, 6, 1'b0);
      tick();
    end
    chk_bus("own6_last", 32'h40, 6, 1'b0);
    req = 32'h0000_0002;
    tick();
    chk_bus("coinc_turn", 32'h0, 0, 1'b0);
    tick();
    chk_bus("own1", 32'h2, 1, 1'b0);
    req = 32'h0;
    tick();
    tick();

    // async reset during ownership of 12
    req = 32'h0000_1000;
    tick();
    chk_bus("own12", 32'h1000, 12, 1'b0);
    req = 32'h1000_1000;
    #2;
    reset_n = 1'b0;
    #1;
    chk_bus("async_rst", 32'h0, 0, 1'b0);
    tick();
    chk_bus("rst_held", 32'h0, 0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_bus("after_rst", 32'h1000, 12, 1'b0);
    req = 32'h0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
